// File: rtl/vrf_pkg.sv
// Shared types for the multi-port vector register file.
package vrf_pkg;

    localparam int VRF_WIDTH = 24;
    localparam int VRF_VLEN  = 8;

    typedef enum logic [1:0] {
        WM_ELEM  = 2'b00,
        WM_VEC   = 2'b01,
        WM_BCAST = 2'b10,
        WM_RSVD  = 2'b11
    } wmode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } vrf_state_e;

    typedef logic [VRF_VLEN-1:0][VRF_WIDTH-1:0] vec_t;

endpackage

// File: rtl/vrf_lane_merge.sv
// Combines an existing vector with one write request, lane by lane.
module vrf_lane_merge
    import vrf_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int VLEN  = 8,
    localparam int IX_W = $clog2(VLEN)
) (
    input  logic [VLEN-1:0][WIDTH-1:0] old_vec,
    input  logic [1:0]                 mode,
    input  logic [IX_W-1:0]            idx,
    input  logic [VLEN-1:0]            mask,
    input  logic [VLEN-1:0][WIDTH-1:0] w_vec,
    input  logic [WIDTH-1:0]           w_scalar,
    output logic [VLEN-1:0][WIDTH-1:0] new_vec
);

    wmode_e mode_s;
    assign mode_s = wmode_e'(mode);

    function automatic logic [WIDTH-1:0] lane_pick(
        input wmode_e           m,
        input logic             hit,
        input logic             en,
        input logic [WIDTH-1:0] old_l,
        input logic [WIDTH-1:0] vec_l,
        input logic [WIDTH-1:0] sc
    );
        logic [WIDTH-1:0] r;
        case (m)
            WM_ELEM:  r = hit ? sc : old_l;
            WM_VEC:   r = en ? vec_l : old_l;
            WM_BCAST: r = en ? sc : old_l;
            default:  r = old_l;
        endcase
        return r;
    endfunction

    // Lane i lives in packed slot VLEN-1-i so that lane 0 is the MSB slice.
    for (genvar g = 0; g < VLEN; g++) begin : g_lane
        assign new_vec[VLEN-1-g] = lane_pick(mode_s, idx == IX_W'(g), mask[g],
                                             old_vec[VLEN-1-g], w_vec[VLEN-1-g], w_scalar);
    end

endmodule

// File: rtl/vregfile_mp.sv
// Vector register file: two read ports with write-first bypass, one merged
// write port, power-up zeroing sequencer and a per-register busy scoreboard.
module vregfile_mp
    import vrf_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int REGNUM = 16,
    parameter int VLEN   = 8,
    localparam int RA_W  = $clog2(REGNUM),
    localparam int IX_W  = $clog2(VLEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [RA_W-1:0]       ra_addr,
    output logic [VLEN*WIDTH-1:0] ra_data,
    input  logic [RA_W-1:0]       rb_addr,
    input  logic [IX_W-1:0]       rb_idx,
    output logic [VLEN*WIDTH-1:0] rb_data,
    output logic [WIDTH-1:0]      rb_scalar,
    input  logic                  we,
    input  logic [1:0]            w_mode,
    input  logic [RA_W-1:0]       w_addr,
    input  logic [IX_W-1:0]       w_idx,
    input  logic [VLEN-1:0]       w_mask,
    input  logic [VLEN*WIDTH-1:0] w_vec,
    input  logic [WIDTH-1:0]      w_scalar,
    input  logic                  w_last,
    input  logic                  rsv_valid,
    input  logic [RA_W-1:0]       rsv_addr,
    output logic                  rsv_ready,
    output logic [REGNUM-1:0]     busy
);

    typedef logic [VLEN-1:0][WIDTH-1:0] lvec_t;

    localparam logic [RA_W:0]       ADDR_END = (RA_W+1)'(REGNUM);
    localparam logic [RA_W-1:0]     LAST_RA  = RA_W'(REGNUM-1);
    localparam logic [IX_W-1:0]     LAST_IX  = IX_W'(VLEN-1);
    localparam logic [REGNUM-1:0]   ONE_HOT0 = REGNUM'(1);

    vrf_state_e        state_r, state_nxt_s;
    logic [RA_W-1:0]   cnt_r;
    logic              init_done_r;
    logic [REGNUM-1:0] busy_r, clr_vec_s, set_vec_s;
    lvec_t             mem_r [REGNUM];

    logic  run_s, wr_s, clr_s, grant_s;
    lvec_t old_w_s, rd_a_s, rd_b_s, mrg_w_s, mrg_a_s, mrg_b_s, ra_vec_s, rb_vec_s;

    function automatic logic addr_ok(input logic [RA_W-1:0] a);
        return {1'b0, a} < ADDR_END;
    endfunction

    assign run_s   = (state_r == ST_RUN);
    assign wr_s    = run_s && we && addr_ok(w_addr);
    assign clr_s   = wr_s && w_last;
    // A same-cycle clear of the requested register blocks the grant.
    assign grant_s = run_s && rsv_valid && addr_ok(rsv_addr) && !busy_r[rsv_addr]
                     && !(clr_s && (w_addr == rsv_addr));

    // Stored operands; INIT and out-of-range reads are forced to zero.
    always_comb begin
        if (run_s && addr_ok(ra_addr)) rd_a_s = mem_r[ra_addr];
        else                           rd_a_s = '0;
        if (run_s && addr_ok(rb_addr)) rd_b_s = mem_r[rb_addr];
        else                           rd_b_s = '0;
        if (addr_ok(w_addr))           old_w_s = mem_r[w_addr];
        else                           old_w_s = '0;
    end

    vrf_lane_merge #(.WIDTH(WIDTH), .VLEN(VLEN)) u_mrg_w (
        .old_vec(old_w_s), .mode(w_mode), .idx(w_idx), .mask(w_mask),
        .w_vec(w_vec), .w_scalar(w_scalar), .new_vec(mrg_w_s)
    );
    vrf_lane_merge #(.WIDTH(WIDTH), .VLEN(VLEN)) u_mrg_a (
        .old_vec(rd_a_s), .mode(w_mode), .idx(w_idx), .mask(w_mask),
        .w_vec(w_vec), .w_scalar(w_scalar), .new_vec(mrg_a_s)
    );
    vrf_lane_merge #(.WIDTH(WIDTH), .VLEN(VLEN)) u_mrg_b (
        .old_vec(rd_b_s), .mode(w_mode), .idx(w_idx), .mask(w_mask),
        .w_vec(w_vec), .w_scalar(w_scalar), .new_vec(mrg_b_s)
    );

    // Write-first bypass select for both read ports.
    always_comb begin
        if (wr_s && (ra_addr == w_addr)) ra_vec_s = mrg_a_s;
        else                             ra_vec_s = rd_a_s;
        if (wr_s && (rb_addr == w_addr)) rb_vec_s = mrg_b_s;
        else                             rb_vec_s = rd_b_s;
    end

    assign ra_data   = ra_vec_s;
    assign rb_data   = rb_vec_s;
    assign rb_scalar = rb_vec_s[LAST_IX - rb_idx];
    assign rsv_ready = grant_s;
    assign busy      = busy_r;
    assign init_done = init_done_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_INIT;
        else     state_r <= state_nxt_s;
    end

    // Next state: leave INIT once the last register has been zeroed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LAST_RA) state_nxt_s = ST_RUN;
                else                  state_nxt_s = ST_INIT;
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Zeroing counter and registered done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            if (state_r == ST_INIT) cnt_r <= cnt_r + RA_W'(1);
            init_done_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Scoreboard set/clear masks.
    always_comb begin
        if (clr_s)   clr_vec_s = ONE_HOT0 << w_addr;
        else         clr_vec_s = '0;
        if (grant_s) set_vec_s = ONE_HOT0 << rsv_addr;
        else         set_vec_s = '0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_r <= '0;
        else     busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;
    end

    // Storage: zero one register per INIT cycle, otherwise commit the merged write.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) mem_r[cnt_r] <= '0;
        else if (wr_s)          mem_r[w_addr] <= mrg_w_s;
    end

endmodule

// File: tb/tb_vregfile_mp.sv
// Scoreboard bench for vregfile_mp: a lane-array reference model predicts each
// cycle's outputs, a monitor pops and compares them on the falling edge.
module tb_vregfile_mp;
    localparam int WIDTH = 24, REGNUM = 16, VLEN = 8, RA_W = 4, IX_W = 3;
    localparam int VW = VLEN * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              init_done, we, w_last, rsv_valid, rsv_ready;
    logic [RA_W-1:0]   ra_addr, rb_addr, w_addr, rsv_addr;
    logic [IX_W-1:0]   rb_idx, w_idx;
    logic [1:0]        w_mode;
    logic [VLEN-1:0]   w_mask;
    logic [VW-1:0]     ra_data, rb_data, w_vec;
    logic [WIDTH-1:0]  rb_scalar, w_scalar;
    logic [REGNUM-1:0] busy;

    vregfile_mp #(.WIDTH(WIDTH), .REGNUM(REGNUM), .VLEN(VLEN)) u_dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .ra_addr(ra_addr), .ra_data(ra_data),
        .rb_addr(rb_addr), .rb_idx(rb_idx), .rb_data(rb_data), .rb_scalar(rb_scalar),
        .we(we), .w_mode(w_mode), .w_addr(w_addr), .w_idx(w_idx), .w_mask(w_mask),
        .w_vec(w_vec), .w_scalar(w_scalar), .w_last(w_last),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .busy(busy)
    );

    // Second instance with a non-power-of-two register count.
    logic            d_init_done, d_we, d_rsv_valid, d_rsv_ready;
    logic [3:0]      d_ra_addr, d_rb_addr, d_w_addr, d_rsv_addr;
    logic [VW-1:0]   d_ra_data, d_rb_data;
    logic [WIDTH-1:0] d_rb_scalar;
    logic [11:0]     d_busy;

    vregfile_mp #(.WIDTH(WIDTH), .REGNUM(12), .VLEN(VLEN)) u_dut12 (
        .clk(clk), .rst(rst), .init_done(d_init_done),
        .ra_addr(d_ra_addr), .ra_data(d_ra_data),
        .rb_addr(d_rb_addr), .rb_idx(rb_idx), .rb_data(d_rb_data), .rb_scalar(d_rb_scalar),
        .we(d_we), .w_mode(w_mode), .w_addr(d_w_addr), .w_idx(w_idx), .w_mask(w_mask),
        .w_vec(w_vec), .w_scalar(w_scalar), .w_last(w_last),
        .rsv_valid(d_rsv_valid), .rsv_addr(d_rsv_addr), .rsv_ready(d_rsv_ready), .busy(d_busy)
    );

    // Reference model: registers as arrays of lanes.
    logic [WIDTH-1:0]  m_mem [REGNUM][VLEN];
    logic [REGNUM-1:0] m_busy;
    bit                m_run;
    int                m_left;

    typedef struct {
        logic [VW-1:0]     ra;
        logic [VW-1:0]     rb;
        logic [WIDTH-1:0]  rs;
        logic              rr;
        logic [REGNUM-1:0] bz;
        logic              dn;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    logic [VW-1:0] cv;
    int n;

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit lane_hit(input int i);
        case (w_mode)
            2'b00:        return i == int'(w_idx);
            2'b01, 2'b10: return w_mask[i] == 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] new_lane(input int i);
        if (w_mode == 2'b01) return w_vec[(VLEN-1-i)*WIDTH +: WIDTH];
        else                 return w_scalar;
    endfunction

    function automatic logic [VW-1:0] exp_read(input logic [RA_W-1:0] a);
        logic [VW-1:0]    v;
        logic [WIDTH-1:0] e;
        v = '0;
        if (m_run) begin
            for (int i = 0; i < VLEN; i++) begin
                e = m_mem[a][i];
                if (we && a == w_addr && lane_hit(i)) e = new_lane(i);
                v[(VLEN-1-i)*WIDTH +: WIDTH] = e;
            end
        end
        return v;
    endfunction

    function automatic logic exp_ready();
        return m_run && rsv_valid && !m_busy[rsv_addr] && !(we && w_last && w_addr == rsv_addr);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.ra = exp_read(ra_addr);
        e.rb = exp_read(rb_addr);
        e.rs = e.rb[(VLEN-1-int'(rb_idx))*WIDTH +: WIDTH];
        e.rr = exp_ready();
        e.bz = m_busy;
        e.dn = m_run;
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic g;
        @(posedge clk);
        if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                for (int r = 0; r < REGNUM; r++)
                    for (int i = 0; i < VLEN; i++) m_mem[r][i] = '0;
            end
        end else begin
            g = exp_ready();
            if (we) begin
                for (int i = 0; i < VLEN; i++)
                    if (lane_hit(i)) m_mem[w_addr][i] = new_lane(i);
                if (w_last) m_busy[w_addr] = 1'b0;
            end
            if (g) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we = 1'b0; w_mode = 2'b00; w_addr = '0; w_idx = '0; w_mask = '0; w_vec = '0;
        w_scalar = '0; w_last = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
        ra_addr = '0; rb_addr = '0; rb_idx = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_run = 1'b0; m_left = REGNUM; m_busy = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic measure_init(input string nm);
        n = 0;
        while (init_done !== 1'b1 && n < 40) begin
            push_exp(); step(); n++;
        end
        check(nm, VW'(n), VW'(16));
    endtask

    // Monitor: compare every predicted cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ra_data", ra_data, e.ra);
                check("rb_data", rb_data, e.rb);
                check("rb_scalar", VW'(rb_scalar), VW'(e.rs));
                check("rsv_ready", VW'(rsv_ready), VW'(e.rr));
                check("busy", VW'(busy), VW'(e.bz));
                check("init_done", VW'(init_done), VW'(e.dn));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        d_we = 1'b0; d_rsv_valid = 1'b0; d_w_addr = '0; d_rsv_addr = '0;
        d_ra_addr = '0; d_rb_addr = '0;
        @(posedge clk); #1;
        do_reset();

        // Init length, reservation blocked during INIT, all registers zero.
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        measure_init("init_len");
        idle();
        for (int r = 0; r < REGNUM; r++) begin
            ra_addr = RA_W'(r); rb_addr = RA_W'(REGNUM-1-r); rb_idx = IX_W'(r);
            push_exp(); step();
        end

        // Element write with bypass, then stored.
        idle(); we = 1'b1; w_mode = 2'b00; w_addr = 4'd3; w_idx = 3'd5; w_scalar = 24'hABCDEF;
        rb_addr = 4'd3; rb_idx = 3'd5;
        push_exp(); @(negedge clk); #1;
        check("elem_bypass", VW'(rb_scalar), VW'(24'hABCDEF));
        step();
        idle(); ra_addr = 4'd3; push_exp(); @(negedge clk); #1;
        cv = {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hABCDEF, 24'h0, 24'h0};
        check("elem_stored", ra_data, cv);
        step();

        // Masked vector write then masked broadcast.
        idle(); we = 1'b1; w_mode = 2'b01; w_addr = 4'd7; w_mask = 8'b0000_1111;
        w_vec = {24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8};
        push_exp(); step();
        idle(); ra_addr = 4'd7; push_exp(); @(negedge clk); #1;
        cv = {24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0, 24'd0, 24'd0};
        check("vec_masked", ra_data, cv);
        step();
        idle(); we = 1'b1; w_mode = 2'b10; w_addr = 4'd7; w_mask = 8'b1000_0000;
        w_scalar = 24'h55; ra_addr = 4'd7;
        push_exp(); @(negedge clk); #1;
        cv = {24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0, 24'd0, 24'h55};
        check("bcast_bypass", ra_data, cv);
        step();

        // Scoreboard handshake.
        idle(); rsv_valid = 1'b1; rsv_addr = 4'd2;
        push_exp(); @(negedge clk); #1; check("rsv_grant", VW'(rsv_ready), VW'(1'b1));
        step(); check("busy_set", VW'(busy[2]), VW'(1'b1));
        push_exp(); @(negedge clk); #1; check("rsv_rereq", VW'(rsv_ready), VW'(1'b0));
        step();
        we = 1'b1; w_mode = 2'b11; w_addr = 4'd2; w_last = 1'b1;
        push_exp(); @(negedge clk); #1; check("rsv_vs_clear", VW'(rsv_ready), VW'(1'b0));
        step(); check("busy_clear", VW'(busy[2]), VW'(1'b0));
        idle(); rsv_valid = 1'b1; rsv_addr = 4'd2;
        push_exp(); @(negedge clk); #1; check("rsv_regrant", VW'(rsv_ready), VW'(1'b1));
        step();

        // Randomized traffic with frequent address collisions.
        for (int k = 0; k < 600; k++) begin
            we = 1'($urandom_range(0, 1)); w_mode = 2'($urandom_range(0, 3));
            w_addr = RA_W'($urandom_range(0, 15)); w_idx = IX_W'($urandom_range(0, 7));
            w_mask = VLEN'($urandom);
            w_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            w_scalar = WIDTH'($urandom); w_last = ($urandom_range(0, 3) == 0);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr = ($urandom_range(0, 1) == 0) ? w_addr : RA_W'($urandom_range(0, 15));
            ra_addr = ($urandom_range(0, 1) == 0) ? w_addr : RA_W'($urandom_range(0, 15));
            rb_addr = ($urandom_range(0, 1) == 0) ? w_addr : RA_W'($urandom_range(0, 15));
            rb_idx = IX_W'($urandom_range(0, 7));
            push_exp(); step();
        end

        // Reset in the middle of INIT restarts the sequence.
        idle(); do_reset();
        repeat (5) begin push_exp(); step(); end
        do_reset();
        measure_init("init_len_restart");
        check("busy_after_rst", VW'(busy), VW'(0));

        // Out-of-range access on the 12-register instance.
        idle(); w_mode = 2'b00; w_idx = 3'd0; w_scalar = 24'h123456; w_last = 1'b1;
        d_we = 1'b1; d_w_addr = 4'd13; d_rsv_valid = 1'b1; d_rsv_addr = 4'd13;
        d_ra_addr = 4'd13; d_rb_addr = 4'd13;
        push_exp(); @(negedge clk); #1;
        check("oor_done", VW'(d_init_done), VW'(1'b1));
        check("oor_rsv", VW'(d_rsv_ready), VW'(1'b0));
        check("oor_ra", d_ra_data, VW'(0));
        check("oor_rs", VW'(d_rb_scalar), VW'(0));
        step(); check("oor_busy", VW'(d_busy), VW'(0));
        check("oor_ra_after", d_ra_data, VW'(0));
        w_last = 1'b0; d_w_addr = 4'd11; d_rsv_addr = 4'd11; d_ra_addr = 4'd11;
        push_exp(); @(negedge clk); #1;
        check("r11_rsv", VW'(d_rsv_ready), VW'(1'b1));
        cv = {24'h123456, 168'h0};
        check("r11_bypass", d_ra_data, cv);
        step(); check("r11_busy", VW'(d_busy), VW'(12'h800));
        d_we = 1'b0; d_rsv_valid = 1'b0; idle();

        step(); @(negedge clk); #1;
        check("queue_drained", VW'(exp_q.size()), VW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vregfile_mp.md
Name: vregfile_mp

Overview:
- Parametrised vector register file for the vector datapath.
- Two read ports: one vector read, one vector-plus-scalar read.
- One write port with three modes: single element, lane-masked vector, masked scalar broadcast.
- Adds a zeroing init sequencer after reset and a per-register busy scoreboard with a reservation handshake for in-flight results.

Parameters:
WIDTH, 24, element width in bits
REGNUM, 16, number of vector registers
VLEN, 8, elements per vector register
RA_W, $clog2(REGNUM), register address width (derived, not overridden)
IX_W, $clog2(VLEN), element index width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
init_done  out  1  high once storage zeroing is complete
ra_addr  in  RA_W  read port A register select
ra_data  out  VLEN*WIDTH  read port A full vector
rb_addr  in  RA_W  read port B register select
rb_idx  in  IX_W  read port B element select
rb_data  out  VLEN*WIDTH  read port B full vector
rb_scalar  out  WIDTH  read port B element rb_idx
we  in  1  write enable
w_mode  in  2  00 element, 01 masked vector, 10 masked broadcast, 11 reserved
w_addr  in  RA_W  write register select
w_idx  in  IX_W  element index (mode 00)
w_mask  in  VLEN  lane enables (modes 01/10), bit i = lane i
w_vec  in  VLEN*WIDTH  vector write data (mode 01)
w_scalar  in  WIDTH  scalar data (modes 00/10)
w_last  in  1  final write of a result; clears busy of w_addr
rsv_valid  in  1  request to reserve rsv_addr
rsv_addr  in  RA_W  register to reserve
rsv_ready  out  1  reservation granted this cycle
busy  out  REGNUM  scoreboard, bit r = register r has a pending result

Behaviour:
Vector packing:
- Lane 0 occupies the most significant WIDTH bits of any VLEN*WIDTH bus; lane VLEN-1 occupies the least significant bits.
- The same packing applies to w_vec.
- This matches the existing datapath ordering.

Reset:
- rst high asynchronously clears busy to 0, init_done to 0 and the init counter to 0, and puts the FSM in INIT.
- Storage contents are not reset directly.

FSM:
- INIT: each cycle, zero all lanes of register cnt, then cnt++.
- INIT -> RUN after register REGNUM-1 is zeroed, so INIT lasts exactly REGNUM cycles after rst falls.
- init_done is registered and rises in the first RUN cycle.
- RUN persists until rst.
- rst asserted mid-INIT restarts from register 0.

In INIT:
- we and rsv_valid are ignored; rsv_ready=0.
- ra_data, rb_data and rb_scalar read 0.

Writes (RUN, we=1), committed at the clock edge:
- 00: lane w_idx <= w_scalar; w_mask ignored.
- 01: lane i <= w_vec lane i where w_mask[i]=1.
- 10: lane i <= w_scalar where w_mask[i]=1.
- 11: no storage change; busy still cleared if w_last.
- A mask of all zero is a legal no-op.

Reads:
- Combinational with write-first bypass.
- If we=1 in RUN and the read address equals w_addr, the output shows the post-write value lane by lane: written lanes show new data, other lanes show stored data.

Scoreboard:
- rsv_ready = RUN && rsv_valid && !busy[rsv_addr], evaluated on the start-of-cycle busy value.
- On grant, busy[rsv_addr] sets at the edge.
- we && w_last in RUN clears busy[w_addr] at the edge.
- Same-cycle clear and reserve of the same register: rsv_ready=0 and the clear wins.
- Clear and grant to different registers both take effect.
- Writes to a non-busy register are permitted; the scoreboard is not checked.

Addressing:
- Addresses >= REGNUM (REGNUM not a power of 2): writes and reservations are ignored (rsv_ready=0).
- Reads at such addresses return 0.

Latency:
- Write to visible-on-read: 0 cycles via bypass, then stored.
- Reservation: busy is visible the next cycle.

Decomposition:
- Package vrf_pkg holds:
  - enum wmode_e (WM_ELEM, WM_VEC, WM_BCAST, WM_RSVD);
  - typedef vec_t = logic [VLEN-1:0][WIDTH-1:0];
  - state enum vrf_state_e (ST_INIT, ST_RUN).
- One sub-module, vrf_lane_merge: combinational. It takes the old vector, mode, idx, mask, w_vec and w_scalar, and produces the merged vector. It is reused for the storage update and for both bypass paths.

Test Plan:
1. Init: pulse rst, sample during INIT -> init_done=0 for exactly 16 cycles after rst falls. rsv_valid=1 during INIT gives rsv_ready=0. After init, reading every register returns 0.
2. Element write: we=1, mode=00, w_addr=3, w_idx=5, w_scalar=0xABCDEF -> same cycle, rb_addr=3/rb_idx=5 gives rb_scalar=0xABCDEF (bypass). Next cycle ra_addr=3 gives lane 5 = 0xABCDEF and other lanes 0.
3. Masked vector write then broadcast:
   - Mode 01, w_addr=7, w_mask=8'b0000_1111, w_vec lanes = i+1: lanes 0-3 = 1..4, lanes 4-7 = 0.
   - Then mode 10, w_mask=8'b1000_0000, w_scalar=0x55: lane 7 = 0x55, lanes 0-3 unchanged.
4. Scoreboard:
   - rsv_valid, addr 2 -> rsv_ready=1, busy[2]=1 next cycle.
   - Re-request 2 -> rsv_ready=0.
   - Write to 2 with w_last=1 while rsv_addr=2 -> rsv_ready=0 and busy[2]=0 next cycle.
   - Request again -> granted.
5. Reset mid-init: assert rst after 5 INIT cycles, release -> init_done rises exactly 16 cycles after the second release. busy is all 0.
6. Out-of-range (REGNUM=12): write to addr 13 and reserve 13 -> rsv_ready=0, busy unchanged, and reading addr 13 returns 0.
